// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - Slave I2S receiver: oversampled BCLK/LRCLK/SDATA, word alignment, left/right capture
// Samples async I2S lines with clk, locks to LRCLK edges and commits left/right words.
module i2s_receiver #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  BCLK,
  input  logic                  LRCLK,
  input  logic                  SDATA,
  output logic [DATA_WIDTH-1:0] leftAudio,
  output logic [DATA_WIDTH-1:0] rightAudio,
  output logic                  valid,
  output logic                  RightNLeft,
  output logic                  locked
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                state, state_next;
  logic [2:0]            bclk_q;
  logic [1:0]            lr_q;
  logic [1:0]            sd_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_ins;
  logic                  ws_prev;
  logic                  left_seen;
  logic                  rise;
  logic                  ws;
  logic                  sd;
  logic                  boundary;
  logic                  room;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_q <= '0;
      lr_q   <= '0;
      sd_q   <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], BCLK};
      lr_q   <= {lr_q[0], LRCLK};
      sd_q   <= {sd_q[0], SDATA};
    end
  end

  assign rise     = bclk_q[1] & ~bclk_q[2];
  assign ws       = lr_q[1];
  assign sd       = sd_q[1];
  assign boundary = (ws != ws_prev);
  assign room     = (cnt < CW'(DATA_WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= UNLOCKED;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    shreg_ins  = shreg;
    if (!enable)
      state_next = UNLOCKED;
    else if (rise && state == UNLOCKED && boundary)
      state_next = LOCKED;
    // Current word with this edge's bit dropped into its MSB-first slot
    for (int i = 0; i < DATA_WIDTH; i++)
      if (room && int'(cnt) == DATA_WIDTH - 1 - i)
        shreg_ins[i] = sd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leftAudio  <= '0;
      rightAudio <= '0;
      valid      <= 1'b0;
      RightNLeft <= 1'b0;
      locked     <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      ws_prev    <= 1'b0;
      left_seen  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        locked    <= 1'b0;
        left_seen <= 1'b0;
        // Track LRCLK while idle so re-lock waits for a transition seen after re-enable
        ws_prev   <= ws;
      end else if (rise) begin
        if (state == UNLOCKED) begin
          ws_prev <= ws;
          if (boundary) begin
            locked    <= 1'b1;
            cnt       <= '0;
            shreg     <= '0;
            left_seen <= 1'b0;
          end
        end else if (!boundary) begin
          if (room) begin
            shreg <= shreg_ins;
            cnt   <= cnt + 1'b1;
          end
        end else begin
          // One-bit I2S delay: this edge still carries the previous word's LSB slot
          if (ws_prev) begin
            rightAudio <= shreg_ins;
            valid      <= left_seen;
            left_seen  <= 1'b0;
          end else begin
            leftAudio  <= shreg_ins;
            left_seen  <= 1'b1;
          end
          shreg      <= '0;
          cnt        <= '0;
          ws_prev    <= ws;
          RightNLeft <= ws;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - Directed bench for i2s_receiver driving a BCLK=clk/8 I2S bus model
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        BCLK = 1'b0;
  logic        LRCLK = 1'b0;
  logic        SDATA = 1'b0;
  logic [11:0] leftAudio;
  logic [11:0] rightAudio;
  logic        valid;
  logic        RightNLeft;
  logic        locked;

  int checks = 0;
  int passes = 0;
  int vcount = 0;
  int wide = 0;
  int lat = 0;
  int v0 = 0;
  logic valid_d = 1'b0;
  logic carry = 1'b0;

  i2s_receiver #(.DATA_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .enable(enable), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA),
    .leftAudio(leftAudio), .rightAudio(rightAudio), .valid(valid),
    .RightNLeft(RightNLeft), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) vcount++;
    if (valid && valid_d) wide++;
    valid_d = valid;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic ws, input logic sd);
    LRCLK = ws;
    SDATA = sd;
    BCLK  = 1'b0;
    repeat (4) @(negedge clk);
    BCLK = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (valid) lat = k;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, (i == 0) ? carry : l[n-i]);
    for (int i = 0; i < n; i++) send_bit(1'b1, (i == 0) ? l[0] : r[n-i]);
    carry = r[0];
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_left", 16'(leftAudio), 16'h000);
    chk("rst_right", 16'(rightAudio), 16'h000);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_rnl", 16'(RightNLeft), 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    rst = 1'b1;

    send_frame(16'hA5C, 16'h3C1, 12);
    chk("bfm_locked", 16'(locked), 16'h1);
    chk("bfm_rnl", 16'(RightNLeft), 16'h0);
    send_frame(16'hA5C, 16'h3C1, 12);
    chk("bfm_no_valid_first_right", 16'(vcount), 16'd0);
    chk("bfm_rnl_right", 16'(RightNLeft), 16'h1);
    lat = 0;
    send_frame(16'hA5C, 16'h3C1, 12);
    chk("bfm_vcount", 16'(vcount), 16'd1);
    chk("bfm_left", 16'(leftAudio), 16'hA5C);
    chk("bfm_right", 16'(rightAudio), 16'h3C1);
    chk("bfm_latency_le4", 16'(lat >= 1 && lat <= 4), 16'h1);

    v0 = vcount;
    repeat (3) send_frame(16'h000, 16'hFFF, 12);
    chk("loop_vcount", 16'(vcount - v0), 16'd3);
    chk("loop_left", 16'(leftAudio), 16'h000);
    chk("loop_right", 16'(rightAudio), 16'hFFF);

    v0 = vcount;
    repeat (3) send_frame(16'h00AB, 16'h0012, 8);
    chk("short_vcount", 16'(vcount - v0), 16'd3);
    chk("short_left", 16'(leftAudio), 16'hAB0);
    chk("short_right", 16'(rightAudio), 16'h120);

    v0 = vcount;
    repeat (3) send_frame(16'h1234, 16'hFEDC, 16);
    chk("long_vcount", 16'(vcount - v0), 16'd3);
    chk("long_left", 16'(leftAudio), 16'h123);
    chk("long_right", 16'(rightAudio), 16'hFED);

    send_bit(1'b0, carry);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_left", 16'(leftAudio), 16'h000);
    chk("mrst_right", 16'(rightAudio), 16'h000);
    chk("mrst_locked", 16'(locked), 16'h0);
    chk("mrst_valid", 16'(valid), 16'h0);
    rst = 1'b1;
    v0 = vcount;
    send_frame(16'hA5C, 16'h3C1, 12);
    chk("mrst_relock", 16'(locked), 16'h1);
    send_frame(16'hA5C, 16'h3C1, 12);
    send_frame(16'hA5C, 16'h3C1, 12);
    chk("mrst_vcount", 16'(vcount - v0), 16'd1);
    chk("mrst_left2", 16'(leftAudio), 16'hA5C);
    chk("mrst_right2", 16'(rightAudio), 16'h3C1);

    LRCLK = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    chk("midr_locked", 16'(locked), 16'h1);
    v0 = vcount;
    send_frame(16'hA5C, 16'h3C1, 12);
    chk("midr_no_valid", 16'(vcount - v0), 16'd0);
    send_frame(16'hA5C, 16'h3C1, 12);
    chk("midr_vcount", 16'(vcount - v0), 16'd1);
    chk("midr_left", 16'(leftAudio), 16'hA5C);
    chk("midr_right", 16'(rightAudio), 16'h3C1);

    enable = 1'b0;
    v0 = vcount;
    repeat (3) send_frame(16'h111, 16'h222, 12);
    chk("dis_vcount", 16'(vcount - v0), 16'd0);
    chk("dis_left", 16'(leftAudio), 16'hA5C);
    chk("dis_right", 16'(rightAudio), 16'h3C1);
    chk("dis_locked", 16'(locked), 16'h0);
    enable = 1'b1;
    repeat (2) send_frame(16'h5A5, 16'h0F0, 12);
    chk("en_vcount", 16'(vcount - v0), 16'd1);
    chk("en_left", 16'(leftAudio), 16'h5A5);
    chk("en_right", 16'(rightAudio), 16'h0F0);
    chk("en_locked", 16'(locked), 16'h1);

    chk("valid_single_clk", 16'(wide), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Slave-side I2S receiver: the capture end of the link driven by our I2S master (BCLK, LRCLK, SDATA).
- All three lines are asynchronous to clk. The block oversamples them with clk, deserialises standard (Philips) I2S frames and presents parallel left/right samples with a frame-valid strobe.
- It sits at the codec/ADC-facing edge of the audio path and feeds downstream sample processing.

Parameters:
DATA_WIDTH, 12, bits captured per channel word (MSB first)

Ports:
clk  input  1  system clock; must be ≥4× BCLK frequency; BCLK high and low phases each ≥2 clk
rst  input  1  asynchronous, active-low reset
enable  input  1  1 = receive; 0 = ignore the bus, drop lock, hold outputs
BCLK  input  1  I2S bit clock (async)
LRCLK  input  1  I2S word select: 0 = left, 1 = right (async)
SDATA  input  1  I2S serial data (async), valid on rising BCLK
leftAudio  output  DATA_WIDTH  last complete left word
rightAudio  output  DATA_WIDTH  last complete right word
valid  output  1  one-clk pulse: a new left/right pair is available
RightNLeft  output  1  channel currently being shifted in (registered LRCLK sample)
locked  output  1  1 once word alignment has been established

Behaviour:
- Input synchronisation and edge detection:
  - BCLK, LRCLK and SDATA each pass through a 2-flop synchroniser, so all three have equal latency.
  - A third BCLK flop gives a one-clk rise pulse.
  - All receive logic acts only in clk cycles where the rise pulse is 1 and enable=1.
- Reset (rst=0, async): leftAudio=0, rightAudio=0, valid=0, RightNLeft=0, locked=0, state=UNLOCKED, bit counter=0, shift register=0, ws_prev=0, left_seen=0. Synchroniser flops clear to 0.
- Per rise pulse, sample ws=LRCLK_s and sd=SDATA_s.
- State UNLOCKED:
  - On each rise pulse, ws_prev<=ws.
  - If ws≠ws_prev → go to LOCKED, locked<=1, counter<=0, shift register<=0, left_seen<=0. The bit on this edge is discarded.
- State LOCKED, ws==ws_prev (bit of current word):
  - If counter<DATA_WIDTH: shreg[DATA_WIDTH-1-counter]<=sd, counter<=counter+1.
  - If counter≥DATA_WIDTH: the bit is ignored and counter saturates at DATA_WIDTH.
- State LOCKED, ws≠ws_prev (word boundary; I2S one-bit delay means this bit is still the LSB slot of the previous word):
  - First store sd as above if counter<DATA_WIDTH.
  - Then commit the word to leftAudio if ws_prev=0, else to rightAudio.
  - Then clear shreg and counter; ws_prev<=ws; RightNLeft<=ws.
- Word length rules:
  - Short words (fewer than DATA_WIDTH bits) are left-justified and zero-padded in the LSBs.
  - Long words are truncated to the first DATA_WIDTH bits (the MSBs).
- Commit side effects:
  - A left commit sets left_seen=1.
  - A right commit with left_seen=1 pulses valid for exactly one clk and clears left_seen. A right commit with left_seen=0 updates rightAudio without a valid pulse.
  - The right-commit cycle therefore marks the first new pair after lock.
- Latency:
  - Rise pulse appears 3 clk after the BCLK pin rises.
  - Outputs update on the clk edge that consumes the pulse.
  - BCLK pin rise → valid high ≤4 clk.
- enable=0: rise pulses are ignored; state<=UNLOCKED, locked<=0, left_seen<=0, valid<=0. leftAudio, rightAudio and RightNLeft hold. Re-enabling requires a fresh LRCLK transition to re-lock.
- Reset asserted mid-word: immediate return to reset values; the partial word is lost.
- Output change discipline: leftAudio and rightAudio change only on their commit cycle; otherwise they are stable.

Test Plan:
- Loopback with our I2S master + bit-clock generator, rightAudio=12'hFFF, leftAudio=12'h000, enable=1, rst pulsed low → locked=1 after the first LRCLK edge; after the first full L+R pair, every valid pulse shows leftAudio=12'h000, rightAudio=12'hFFF; exactly one valid per LRCLK period.
- Bus-functional model, 12-bit words, left=12'hA5C, right=12'h3C1, BCLK=clk/8 → after lock: leftAudio=12'hA5C, rightAudio=12'h3C1; valid is a single-clk pulse ≤4 clk after the BCLK rise carrying the LRCLK 1→0 change.
- Short words: 8-bit left 8'hAB, 8-bit right 8'h12 → leftAudio=12'hAB0, rightAudio=12'h120.
- Long words: 16-bit left 16'h1234, right 16'hFEDC → leftAudio=12'h123, rightAudio=12'hFED; no extra valid pulses.
- Start mid-right-word: first partial word discarded; first right commit after lock (no left yet) gives no valid pulse; next pair gives valid with correct data.
- Disruption:
  - rst low for 2 clk mid-left-word → all outputs 0, locked=0; re-lock on the next LRCLK edge.
  - enable=0 for 3 frames → leftAudio and rightAudio hold, valid stays 0, locked=0; after enable=1, valid resumes within two LRCLK periods.
